// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg -- shared encodings for the control unit, the X/Y/Z register
// bank and the ULA.
//   * register control codes (tx/ty/tz): CLEAR, LOAD, HOLD, SHIFTR
//   * ULA select codes (tula): ADD, SUB, default NOP value
//   * opcode values accepted by unidade_controle
//   * sequencer state encoding and the bundled control word
package cpu_ctrl_pkg;

  localparam int W_CODE = 4;
  typedef logic [W_CODE-1:0] code_t;

  // register control codes
  localparam code_t CTL_CLEAR  = 4'd0;
  localparam code_t CTL_LOAD   = 4'd1;
  localparam code_t CTL_HOLD   = 4'd2;
  localparam code_t CTL_SHIFTR = 4'd3;

  // ULA select codes; NOP is deliberately not 0 so an idle ULA never looks like ADD
  localparam code_t ULA_ADD     = 4'd0;
  localparam code_t ULA_SUB     = 4'd1;
  localparam code_t ULA_NOP_DEF = 4'd15;

  // opcodes; anything above OP_CLRALL is illegal
  localparam code_t OP_NOP    = 4'd0;
  localparam code_t OP_LDX    = 4'd1;
  localparam code_t OP_ADD    = 4'd2;
  localparam code_t OP_CLRY   = 4'd3;
  localparam code_t OP_SHR    = 4'd4;
  localparam code_t OP_MOVZ   = 4'd5;
  localparam code_t OP_CLRALL = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2,
    ST_TRAP = 2'd3
  } uc_state_t;

  typedef struct packed {
    code_t tx;
    code_t ty;
    code_t tz;
    code_t tula;
  } ctrl_t;

  function automatic logic op_legal(input code_t op);
    return op <= OP_CLRALL;
  endfunction

  // control word driven whenever no operation is executing
  function automatic ctrl_t ctrl_idle(input code_t nop);
    ctrl_t c;
    c.tx   = CTL_HOLD;
    c.ty   = CTL_HOLD;
    c.tz   = CTL_HOLD;
    c.tula = nop;
    return c;
  endfunction

  // control word for one EXEC cycle; illegal opcodes decode as NOP
  function automatic ctrl_t decode(input code_t op, input code_t opr, input code_t nop);
    ctrl_t c;
    c = ctrl_idle(nop);
    case (op)
      OP_LDX:    c.tx = CTL_LOAD;
      OP_ADD:    begin c.ty = CTL_LOAD; c.tula = ULA_ADD; end
      OP_CLRY:   c.ty = CTL_CLEAR;
      OP_SHR:    c.ty = (opr != '0) ? CTL_SHIFTR : CTL_HOLD;
      OP_MOVZ:   c.tz = CTL_LOAD;
      OP_CLRALL: begin c.tx = CTL_CLEAR; c.ty = CTL_CLEAR; c.tz = CTL_CLEAR; end
      default:   c = ctrl_idle(nop);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uc_contador_repeticao.sv
// uc_contador_repeticao -- loadable down-counter that sequences repeated SHR.
//   clock   : clock, all updates on posedge
//   reset_n : asynchronous active-low reset (count -> 0)
//   load    : load din (priority over dec)
//   dec     : decrement, saturates at zero
//   din     : load value
//   count   : current value
//   zero    : count == 0
module uc_contador_repeticao #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    count <= '0;
    else if (load)                   count <= din;
    else if (dec && (count != '0))   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle -- instruction sequencer feeding the X/Y/Z register bank
// and the ULA. One opcode/operand pair is accepted per valid/ready handshake
// in IDLE; the decoded control word is held for one EXEC cycle (or operand
// cycles for SHR), then DONE pulses for one cycle before returning to IDLE.
// All outputs are registers.
//   clock, reset_n     : clock, asynchronous active-low reset
//   instr_valid/ready  : instruction handshake (ready only in IDLE)
//   opcode, operand    : instruction; operand is the SHR repeat count
//   tx, ty, tz, tula   : register control codes and ULA select
//   busy               : EXEC or DONE
//   done               : one-cycle retire pulse
//   trap               : illegal-opcode trap
// Build option CU_ILLEGAL_TRAP_EN: when defined, an illegal opcode parks the
// block in TRAP (trap=1, ready=0, no done) until reset; when undefined it
// retires as a NOP and trap is tied low.
module unidade_controle
  import cpu_ctrl_pkg::*;
#(
  parameter int          W_CODE   = cpu_ctrl_pkg::W_CODE,
  parameter logic [3:0]  TULA_NOP = ULA_NOP_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [W_CODE-1:0] opcode,
  input  logic [W_CODE-1:0] operand,
  output logic [W_CODE-1:0] tx,
  output logic [W_CODE-1:0] ty,
  output logic [W_CODE-1:0] tz,
  output logic [W_CODE-1:0] tula,
  output logic              busy,
  output logic              done,
  output logic              trap
);

  uc_state_t         state;
  code_t             op_q;
  code_t             opr_q;
  ctrl_t             ctl;

  logic              accept;
  logic              cnt_dec;
  logic [W_CODE-1:0] cnt_din;
  logic [W_CODE-1:0] cnt;
  logic              cnt_zero;
  logic              last_exec;

  // instr_ready is high exactly in IDLE, so this is the handshake
  assign accept  = (state == ST_IDLE) && instr_valid;
  // only SHR repeats; every other op gets a zero count and retires after one cycle
  assign cnt_din = (opcode == OP_SHR) ? operand : '0;
  assign cnt_dec = (state == ST_EXEC);
  // count holds the cycles still to run including the current one
  assign last_exec = cnt_zero || (cnt == W_CODE'(1));

  uc_contador_repeticao #(.W(W_CODE)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .dec     (cnt_dec),
    .din     (cnt_din),
    .count   (cnt),
    .zero    (cnt_zero)
  );

`ifdef CU_ILLEGAL_TRAP_EN
  logic trap_q;
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_NOP;
      opr_q       <= '0;
      ctl         <= ctrl_idle(TULA_NOP);
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q        <= opcode;
            opr_q       <= operand;
            instr_ready <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            if (!op_legal(opcode)) begin
              state  <= ST_TRAP;
              trap_q <= 1'b1;
            end else begin
              state <= ST_EXEC;
              busy  <= 1'b1;
              ctl   <= decode(opcode, operand, TULA_NOP);
            end
`else
            state <= ST_EXEC;
            busy  <= 1'b1;
            ctl   <= decode(opcode, operand, TULA_NOP);
`endif
          end
        end
        ST_EXEC: begin
          if (last_exec) begin
            state <= ST_DONE;
            done  <= 1'b1;
            ctl   <= ctrl_idle(TULA_NOP);
          end else begin
            ctl <= decode(op_q, opr_q, TULA_NOP);
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
        end
        ST_TRAP: begin
          // sticky: only reset_n leaves TRAP
          state <= ST_TRAP;
        end
        default: begin
          state       <= ST_IDLE;
          ctl         <= ctrl_idle(TULA_NOP);
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = ctl.tx;
  assign ty   = ctl.ty;
  assign tz   = ctl.tz;
  assign tula = ctl.tula;

endmodule
